// File: rtl/axi4_burst_addr_gen_if.sv
// Command and beat-descriptor channels of the AXI4 burst address sequencer.
// The slave modport is the sequencer's view; the master drives commands and consumes beats.
interface axi4_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic [2:0]            cmd_size;
    logic [1:0]            cmd_burst;

    logic                  beat_valid;
    logic                  beat_ready;
    logic [ID_WIDTH-1:0]   beat_id;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [OFF_W-1:0]      beat_offset;
    logic                  beat_last;
    logic [1:0]            beat_resp;

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_id, beat_addr, beat_offset, beat_last, beat_resp
    );

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_id, beat_addr, beat_offset, beat_last, beat_resp
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address sequencer: turns one AR/AW-style command into one beat descriptor
// per transfer (FIXED/INCR/WRAP), flagging illegal commands with SLVERR on every beat.
module axi4_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input logic                    clk,
    input logic                    rst,
    axi4_burst_addr_gen_if.slave   bus
);
    localparam int         DATA_BYTES  = DATA_WIDTH / 8;
    localparam int         OFF_W       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [2:0] MAX_SIZE    = 3'($clog2(DATA_BYTES));

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_next;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q, cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q, resp_q;
    logic [ADDR_WIDTH-1:0] addr_q, total_q;

    logic                  beat_valid, beat_last, cmd_ready, cmd_accept, beat_fire;
    logic [ADDR_WIDTH-1:0] cmd_bytes, cmd_total, cmd_incr_end;
    logic                  cmd_err;
    logic [ADDR_WIDTH-1:0] cur_bytes, wrap_lower, wrap_inc, addr_next;

    assign beat_valid = (state == BURST);
    assign beat_last  = beat_valid && (cnt_q == len_q);
    assign beat_fire  = beat_valid && bus.beat_ready;
    assign cmd_ready  = (state == IDLE) || (beat_fire && beat_last);
    assign cmd_accept = bus.cmd_valid && cmd_ready;

    assign bus.cmd_ready   = cmd_ready;
    assign bus.beat_valid  = beat_valid;
    assign bus.beat_last   = beat_last;
    assign bus.beat_id     = id_q;
    assign bus.beat_addr   = addr_q;
    assign bus.beat_offset = addr_q[OFF_W-1:0];
    assign bus.beat_resp   = resp_q;

    // Legality of the incoming command is decided once, at accept, and held for the whole burst.
    always_comb begin
        cmd_bytes    = ONE << bus.cmd_size;
        cmd_total    = cmd_bytes * (ADDR_WIDTH'(bus.cmd_len) + ONE);
        cmd_incr_end = (bus.cmd_addr & ~(cmd_bytes - ONE)) + cmd_total - ONE;
        cmd_err      = 1'b0;
        if (bus.cmd_size > MAX_SIZE)
            cmd_err = 1'b1;
        if (bus.cmd_burst == BURST_RSVD)
            cmd_err = 1'b1;
        if (bus.cmd_burst == BURST_WRAP &&
            !(bus.cmd_len == 8'd1 || bus.cmd_len == 8'd3 ||
              bus.cmd_len == 8'd7 || bus.cmd_len == 8'd15))
            cmd_err = 1'b1;
        if (bus.cmd_burst == BURST_WRAP && (bus.cmd_addr & (cmd_bytes - ONE)) != '0)
            cmd_err = 1'b1;
        if (bus.cmd_burst == BURST_INCR &&
            bus.cmd_addr[ADDR_WIDTH-1:12] != cmd_incr_end[ADDR_WIDTH-1:12])
            cmd_err = 1'b1;
        if (bus.cmd_burst == BURST_FIXED && bus.cmd_len > 8'd15)
            cmd_err = 1'b1;
    end

    // Reserved bursts have no defined progression, so they hold the address like FIXED.
    always_comb begin
        cur_bytes  = ONE << size_q;
        wrap_lower = addr_q & ~(total_q - ONE);
        wrap_inc   = addr_q + cur_bytes;
        addr_next  = addr_q;
        case (burst_q)
            BURST_INCR: addr_next = (addr_q & ~(cur_bytes - ONE)) + cur_bytes;
            BURST_WRAP: addr_next = (wrap_inc == wrap_lower + total_q) ? wrap_lower : wrap_inc;
            default:    addr_next = addr_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_next = BURST;
            BURST:   if (beat_fire && beat_last) state_next = bus.cmd_valid ? BURST : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            resp_q  <= RESP_OKAY;
            addr_q  <= '0;
            total_q <= '0;
        end else begin
            state <= state_next;
            if (cmd_accept) begin
                id_q    <= bus.cmd_id;
                len_q   <= bus.cmd_len;
                size_q  <= bus.cmd_size;
                burst_q <= bus.cmd_burst;
                resp_q  <= cmd_err ? RESP_SLVERR : RESP_OKAY;
                addr_q  <= bus.cmd_addr;
                total_q <= cmd_total;
                cnt_q   <= '0;
            end else if (beat_fire) begin
                addr_q <= addr_next;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Randomised bench for axi4_burst_addr_gen: a queue-of-beats reference model is compared
// against the DUT every cycle, with literal test-plan cases pinning the model.
module tb_axi4_burst_addr_gen;
    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam longint     MASK32 = 64'hFFFF_FFFF;

    typedef struct {
        logic [31:0] addr;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   stall_pct = 0;
    int   idle_cycles = 0;
    bit   after_reset = 1'b1;
    bit   ready_exp;
    beat_q_t exp_q;

    axi4_burst_addr_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) bus ();

    axi4_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole burst computed up front from the command, as a list of beats.
    function automatic beat_q_t gen_burst(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst,
                                          input logic [3:0] id);
        beat_q_t q;
        longint  bytes = longint'(1) << size;
        longint  total = bytes * (longint'(len) + 1);
        longint  a     = longint'(addr);
        longint  lower, nxt, end_byte;
        bit      err;
        err = (size > 3) || (burst == RSVD) ||
              (burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == WRAP && (a % bytes) != 0) ||
              (burst == FIXED && len > 15);
        if (burst == INCR) begin
            end_byte = ((a / bytes) * bytes + total - 1) & MASK32;
            if ((end_byte >> 12) != (a >> 12)) err = 1'b1;
        end
        for (int i = 0; i <= int'(len); i++) begin
            q.push_back('{addr: a[31:0], last: (i == int'(len)), resp: (err ? SLVERR : OKAY), id: id});
            case (burst)
                INCR: a = ((a / bytes) * bytes + bytes) & MASK32;
                WRAP: begin
                    lower = a & ~(total - 1);
                    nxt   = (a + bytes) & MASK32;
                    a     = (nxt == ((lower + total) & MASK32)) ? lower : nxt;
                end
                default: a = a;
            endcase
        end
        return q;
    endfunction

    task automatic pinBurst(input string name, input beat_q_t q, input int n,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input logic [1:0] eresp);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        checkOutput({name, "_beats"}, 64'(q.size()), 64'(n));
        for (int i = 0; i < n && i < q.size(); i++) begin
            checkOutput({name, "_addr"}, 64'(q[i].addr), 64'(e[i]));
            checkOutput({name, "_last"}, 64'(q[i].last), 64'(i == n - 1));
            checkOutput({name, "_resp"}, 64'(q[i].resp), 64'(eresp));
        end
    endtask

    // Reference model advances on the same edge as the DUT, from inputs only.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            after_reset = 1'b1;
        end else begin
            ready_exp = (exp_q.size() == 0) || (bus.beat_ready && exp_q.size() == 1);
            if (exp_q.size() != 0 && bus.beat_ready) void'(exp_q.pop_front());
            if (bus.cmd_valid && ready_exp) begin
                exp_q = gen_burst(bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst, bus.cmd_id);
                after_reset = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!bus.beat_valid) idle_cycles++;
        checkOutput("beat_valid", 64'(bus.beat_valid), 64'(exp_q.size() != 0));
        checkOutput("cmd_ready", 64'(bus.cmd_ready),
                    64'((exp_q.size() == 0) || (bus.beat_ready && exp_q.size() == 1)));
        if (exp_q.size() != 0) begin
            checkOutput("beat_addr",   64'(bus.beat_addr),   64'(exp_q[0].addr));
            checkOutput("beat_offset", 64'(bus.beat_offset), 64'(exp_q[0].addr[2:0]));
            checkOutput("beat_last",   64'(bus.beat_last),   64'(exp_q[0].last));
            checkOutput("beat_resp",   64'(bus.beat_resp),   64'(exp_q[0].resp));
            checkOutput("beat_id",     64'(bus.beat_id),     64'(exp_q[0].id));
        end else if (after_reset) begin
            checkOutput("reset_addr",   64'(bus.beat_addr),   64'd0);
            checkOutput("reset_id",     64'(bus.beat_id),     64'd0);
            checkOutput("reset_offset", 64'(bus.beat_offset), 64'd0);
            checkOutput("reset_last",   64'(bus.beat_last),   64'd0);
            checkOutput("reset_resp",   64'(bus.beat_resp),   64'(OKAY));
        end
    end

    initial begin
        bus.beat_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.beat_ready = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic applyStimulus(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] b, input logic [3:0] id);
        int waited = 0;
        bit done = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_size  = s;
        bus.cmd_burst = b;
        bus.cmd_id    = id;
        bus.cmd_valid = 1'b1;
        while (!done && waited < 600) begin
            #4;
            done = bus.cmd_ready;
            @(negedge clk);
            waited++;
        end
        bus.cmd_valid = 1'b0;
        if (!done) checkOutput("cmd_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int snap;
        logic [31:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;
        int          pick;

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_size  = '0;
        bus.cmd_burst = '0;
        bus.cmd_id    = '0;

        pinBurst("pin_incr",   gen_burst(32'h1000, 8'd3, 3'd3, INCR, 4'd0), 4,
                 32'h1000, 32'h1008, 32'h1010, 32'h1018, OKAY);
        pinBurst("pin_wrap",   gen_burst(32'h1018, 8'd3, 3'd3, WRAP, 4'd0), 4,
                 32'h1018, 32'h1000, 32'h1008, 32'h1010, OKAY);
        pinBurst("pin_unalgn", gen_burst(32'h1003, 8'd2, 3'd2, INCR, 4'd0), 3,
                 32'h1003, 32'h1004, 32'h1008, 32'h0, OKAY);
        pinBurst("pin_4kb",    gen_burst(32'h1FF8, 8'd1, 3'd3, INCR, 4'd0), 2,
                 32'h1FF8, 32'h2000, 32'h0, 32'h0, SLVERR);
        pinBurst("pin_size4",  gen_burst(32'h2000, 8'd0, 3'd4, INCR, 4'd0), 1,
                 32'h2000, 32'h0, 32'h0, 32'h0, SLVERR);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'h1000, 8'd3, 3'd3, INCR, 4'd1);
        applyStimulus(32'h1018, 8'd3, 3'd3, WRAP, 4'd2);
        applyStimulus(32'h1003, 8'd2, 3'd2, INCR, 4'd3);
        applyStimulus(32'h1FF8, 8'd1, 3'd3, INCR, 4'd4);
        applyStimulus(32'h2000, 8'd0, 3'd4, INCR, 4'd5);
        drain();

        applyStimulus(32'h4000, 8'd1, 3'd3, INCR, 4'd6);
        snap = idle_cycles;
        applyStimulus(32'h5000, 8'd0, 3'd3, INCR, 4'd7);
        checkOutput("b2b_valid", 64'(bus.beat_valid), 64'd1);
        checkOutput("b2b_addr",  64'(bus.beat_addr),  64'h5000);
        checkOutput("b2b_gap",   64'(idle_cycles),    64'(snap));
        drain();

        applyStimulus(32'h3000, 8'd7, 3'd3, INCR, 4'd8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_valid", 64'(bus.beat_valid), 64'd0);
        checkOutput("rst_mid_ready", 64'(bus.cmd_ready),  64'd1);
        checkOutput("rst_mid_addr",  64'(bus.beat_addr),  64'd0);
        applyStimulus(32'h3100, 8'd2, 3'd3, INCR, 4'd9);
        checkOutput("post_rst_addr", 64'(bus.beat_addr),  64'h3100);
        drain();

        stall_pct = 30;
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            rb = (pick < 3) ? FIXED : (pick < 7) ? INCR : (pick < 9) ? WRAP : RSVD;
            rs = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            if (rb == WRAP && $urandom_range(0, 3) != 0)
                rl = 8'((1 << $urandom_range(1, 4)) - 1);
            else
                rl = 8'($urandom_range(0, 20));
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) ra[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
            if (rb == WRAP && $urandom_range(0, 3) != 0) ra[2:0] = 3'd0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            applyStimulus(ra, rl, rs, rb, 4'($urandom_range(0, 15)));
        end
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi4_burst_addr_gen.md
Name: axi4_burst_addr_gen

Overview:
Parametrised AXI4 burst address sequencer built on the shared AMBA4 types (LEN_T, SIZE_T, BURST_T, RESP_T). It accepts one AR/AW-style command and emits one beat descriptor per data transfer: address, byte-lane offset, last flag and response. It supports FIXED, INCR and WRAP bursts, and adds protocol legality checks that the AMBA4 types do not provide. It sits between slave-side AXI channel decode and the memory/register backend.

Parameters:
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 64, bus data width in bits; power of two from 8 to 1024. DATA_BYTES = DATA_WIDTH/8.
ID_WIDTH, 4, transaction ID width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command ready.
cmd_id  in  ID_WIDTH  transaction ID.
cmd_addr  in  ADDR_WIDTH  start address.
cmd_len  in  8  AxLEN (LEN_T); beats = len+1.
cmd_size  in  3  AxSIZE (SIZE_T).
cmd_burst  in  2  AxBURST (BURST_T).
beat_valid  out  1  beat descriptor valid.
beat_ready  in  1  beat consumed.
beat_id  out  ID_WIDTH  ID of the current burst.
beat_addr  out  ADDR_WIDTH  beat address.
beat_offset  out  log2(DATA_BYTES)  beat_addr modulo DATA_BYTES.
beat_last  out  1  final beat of the burst.
beat_resp  out  2  RESP_OKAY or RESP_SLVERR for the whole burst.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values: state IDLE; beat_valid=0; cmd_ready=1; beat_addr, beat_id and beat_offset=0; beat_last=0; beat_resp=RESP_OKAY.
- States:
  - IDLE: cmd_ready=1. A cmd handshake moves to BURST.
  - BURST: beat_valid=1. When beat_ready && beat_last, go to IDLE, or stay in BURST if a new cmd is accepted in the same cycle.
- cmd_ready = IDLE || (beat_valid && beat_ready && beat_last). This allows back-to-back bursts with no bubble.
- Latency: the first beat is presented the cycle after the cmd handshake. Outputs are registered and stay stable while beat_valid && !beat_ready.
- Latched per burst: id, len, size, burst, resp. bytes = 1<<size. beat counter cnt runs 0..len. beat_last = (cnt==len).
- Beat 0 address = cmd_addr, unaligned permitted for FIXED/INCR. Advancing the address on each beat_valid && beat_ready:
  - FIXED: address unchanged.
  - INCR: next = align(addr, bytes) + bytes, computed modulo 2^ADDR_WIDTH.
  - WRAP: total = bytes*(len+1); lower = addr & ~(total-1); next = addr + bytes; if next == lower+total then next = lower.
- Legality checks are evaluated at cmd accept. Any violation sets resp=RESP_SLVERR:
  - size > log2(DATA_BYTES).
  - burst == BURST_RSVD.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with an unaligned cmd_addr.
  - INCR crossing a 4 KB boundary: (align(addr,bytes) + bytes*(len+1) - 1) lands in a different 4 KB page.
  - FIXED with len > 15.
- On error, len+1 beats are still generated using the same address rules so data-channel beat accounting stays intact. beat_resp=SLVERR on every beat.
- Simultaneous last-beat accept and new cmd: the new burst's beat 0 appears in the next cycle with no idle cycle.
- beat_ready held low: all outputs hold and cnt does not advance.
- rst mid-burst: the burst is abandoned, state returns to IDLE, and reset values apply the next cycle.

Test Plan:
- INCR, addr=0x1000, len=3, size=3 (8B), DATA_WIDTH=64 -> beats 0x1000, 0x1008, 0x1010, 0x1018; last only on 4th beat; resp OKAY.
- WRAP, addr=0x1018, len=3, size=3 -> 0x1018, 0x1000, 0x1008, 0x1010; last on 0x1010.
- INCR unaligned addr=0x1003, len=2, size=2 -> 0x1003 (offset 3), 0x1004, 0x1008; OKAY.
- INCR, addr=0x1FF8, len=1, size=3 crosses 4 KB -> 2 beats 0x1FF8, 0x2000, both SLVERR. Separately, size=4 on a 64-bit bus -> SLVERR.
- Back-to-back: cmd B presented while A's last beat is accepted -> cmd_ready=1 that cycle, B beat 0 next cycle, no gap. Randomised beat_ready stalls -> outputs stable, correct beat count.
- Assert rst during beat 2 of a len=7 INCR -> next cycle beat_valid=0, cmd_ready=1; a subsequent cmd starts cleanly at cnt=0.
